// File: rtl/credit_pkg.sv
// Shared types and widths for the credit-based round-robin arbiter.
package credit_pkg;

  localparam int CREDIT_W = 4;
  localparam int STALL_W  = 16;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_HALT
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester
// after 'last', wrapping N-1 -> 0; an empty request mask gives no grant.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = PTR_W'((int'(last) + off) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_rr_arb.sv
// Round-robin arbiter feeding a downstream FIFO under credit flow control.
// Optional 16-bit stall counter enabled by `define CREDIT_RR_ARB_STALL_CNT_EN.
module credit_rr_arb
  import credit_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int CREDITS = 8
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic [N-1:0]        req_valid,
  input  logic [N*WIDTH-1:0]  req_data,
  output logic [N-1:0]        req_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_we,
  input  logic                credit_ret,
  output logic [CREDIT_W-1:0] credit_cnt,
  output logic                credit_err
`ifdef CREDIT_RR_ARB_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]  stall_cnt
`endif
);

  localparam int                  PTR_W      = $clog2(N);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
  localparam logic [PTR_W-1:0]    PTR_RST    = PTR_W'(N - 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_q, err_d;
  logic                out_we_q, out_we_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;

  logic [N-1:0]        grant;
  logic                arb_en;
  logic                xfer;
  logic [PTR_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    gnt_data;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req   (req_valid),
    .last  (ptr_q),
    .grant (grant)
  );

  // A returned credit only reaches arbitration once it is in credit_q.
  assign arb_en    = (state_q == ST_RUN) && (credit_q != '0);
  assign req_ready = arb_en ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gnt_idx  = PTR_W'(i);
        gnt_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    err_d      = err_q;
    out_we_d   = xfer;
    out_data_d = out_data_q;

    if (xfer) begin
      ptr_d      = gnt_idx;
      out_data_d = gnt_data;
    end

    if (state_q != ST_HALT) begin
      if (xfer && !credit_ret) begin
        credit_d = credit_q - CREDIT_ONE;
      end else if (!xfer && credit_ret) begin
        if (credit_q == CREDIT_MAX) err_d = 1'b1;
        else                        credit_d = credit_q + CREDIT_ONE;
      end
    end

    // WAIT lasts one cycle to cover the downstream FIFO's registered reset.
    case (state_q)
      ST_WAIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HALT;
    endcase
    if (err_d) state_d = ST_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_WAIT;
      ptr_q      <= PTR_RST;
      credit_q   <= CREDIT_MAX;
      err_q      <= 1'b0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      out_we_q   <= out_we_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_we     = out_we_q;
  assign out_data   = out_data_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

`ifdef CREDIT_RR_ARB_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_RUN) && (|req_valid) && (credit_q == '0) && (stall_q != '1))
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_credit_rr_arb.sv
// Self-checking bench for credit_rr_arb: cycle model plus output scoreboard,
// directed scenarios for start-up, credit exhaustion, return and error.
module tb_credit_rr_arb;

  localparam int N       = 4;
  localparam int WIDTH   = 8;
  localparam int CREDITS = 8;

  logic               clk = 1'b0;
  logic               reset_p;
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_we;
  logic               credit_ret;
  logic [3:0]         credit_cnt;
  logic               credit_err;
`ifdef CREDIT_RR_ARB_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  always #5 clk = ~clk;

  credit_rr_arb #(.N(N), .WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_data   (out_data),
    .out_we     (out_we),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
`ifdef CREDIT_RR_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = WAIT, 1 = RUN, 2 = HALT.
  int               m_state;
  int               m_cred;
  int               m_ptr;
  bit               m_err;
  bit               m_we;
  logic [WIDTH-1:0] exp_q[$];
  int               grant_log[$];
  int               exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cred  = CREDITS;
    m_ptr   = N - 1;
    m_err   = 1'b0;
    m_we    = 1'b0;
    exp_q.delete();
    grant_log.delete();
  endtask

  // Asserts reset (possibly mid-cycle), checks the asynchronous reset values,
  // then releases it on the next falling edge.
  task automatic do_reset();
    reset_p    = 1'b1;
    req_valid  = '0;
    credit_ret = 1'b0;
    #1;
    check("rst_req_ready",  req_ready,  '0);
    check("rst_out_we",     out_we,     '0);
    check("rst_out_data",   out_data,   '0);
    check("rst_credit_cnt", credit_cnt, CREDITS);
    check("rst_credit_err", credit_err, '0);
    model_reset();
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic [N-1:0] v, input logic ret);
    int               g;
    logic [WIDTH-1:0] words[N];
    logic [N-1:0]     exp_rdy;
    logic [WIDTH-1:0] d;

    for (int i = 0; i < N; i++) begin
      words[i] = WIDTH'($urandom);
      req_data[i*WIDTH +: WIDTH] = words[i];
    end
    req_valid  = v;
    credit_ret = ret;
    #1;

    g = -1;
    if (m_state == 1 && m_cred > 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      exp_q.push_back(words[g]);
      grant_log.push_back(g);
    end

    @(posedge clk);
    #1;
    m_we = (g >= 0);
    if (g >= 0) m_ptr = g;
    if (m_state != 2) begin
      if (g >= 0 && !ret) m_cred--;
      else if (g < 0 && ret) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else                   m_cred++;
      end
    end
    if (m_state == 0) m_state = 1;
    if (m_err)        m_state = 2;

    check("out_we", out_we, m_we);
    if (m_we && exp_q.size() > 0) begin
      d = exp_q.pop_front();
      check("out_data", out_data, d);
    end
    check("credit_cnt", credit_cnt, m_cred);
    check("credit_err", credit_err, m_err);
    @(negedge clk);
  endtask

  initial begin
    reset_p    = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    credit_ret = 1'b0;

    // Start-up: no grant during WAIT, grant next cycle, write one cycle later.
    do_reset();
    cycle(4'b0001, 1'b0);
    check("start_no_grant_wait", grant_log.size(), 0);
    cycle(4'b0001, 1'b0);
    check("start_grant_count", grant_log.size(), 1);
    check("start_out_we", out_we, 1'b1);

    // Exhaust all credits with every requester valid.
    do_reset();
    cycle('0, 1'b0);
    grant_log.delete();
    repeat (12) cycle(4'hF, 1'b0);
    check("drain_grant_count", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("drain_order", grant_log[k], exp_order[k]);
    check("drain_credit_zero", credit_cnt, 0);
    check("drain_no_ready", req_ready, '0);

    // A single credit return yields exactly one grant, to requester 0.
    grant_log.delete();
    cycle(4'hF, 1'b1);
    check("ret_credit_one", credit_cnt, 1);
    check("ret_no_same_cycle", grant_log.size(), 0);
    repeat (4) cycle(4'hF, 1'b0);
    check("ret_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("ret_grant_req0", grant_log[0], 0);
    check("ret_credit_zero", credit_cnt, 0);

    // Transfer and credit return in the same cycle cancel out.
    do_reset();
    cycle('0, 1'b0);
    repeat (3) cycle(4'b0010, 1'b0);
    check("both_pre_credit", credit_cnt, 5);
    cycle(4'b0100, 1'b1);
    check("both_credit_hold", credit_cnt, 5);
    if (grant_log.size() > 0) check("both_grant_req2", grant_log[grant_log.size()-1], 2);

    // Reset during a write clears out_we without waiting for a clock edge.
    check("midrst_out_we_pre", out_we, 1'b1);
    do_reset();

    // Surplus credit return when full: sticky error, halt.
    cycle('0, 1'b0);
    cycle('0, 1'b0);
    cycle('0, 1'b1);
    check("err_set", credit_err, 1'b1);
    check("err_credit_hold", credit_cnt, CREDITS);
    grant_log.delete();
    repeat (5) cycle(4'hF, 1'b0);
    repeat (3) cycle(4'hF, 1'b1);
    check("halt_no_grant", grant_log.size(), 0);
    check("halt_err_sticky", credit_err, 1'b1);
    check("halt_credit_frozen", credit_cnt, CREDITS);
    check("halt_no_we", out_we, 1'b0);

    // Random traffic with legal credit returns.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      logic r;
      r = (m_cred < CREDITS) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(N'($urandom), r);
    end

`ifdef CREDIT_RR_ARB_STALL_CNT_EN
    do_reset();
    check("stall_rst", stall_cnt, 0);
    cycle('0, 1'b0);
    repeat (8) cycle(4'hF, 1'b0);
    check("stall_pre", stall_cnt, 0);
    repeat (10) cycle(4'b0100, 1'b0);
    check("stall_ten", stall_cnt, 10);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/credit_rr_arb.md
CREDIT_RR_ARB -- requirements
Module: credit_rr_arb

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, data word width.
REQ-003 Parameter CREDITS, default 8, downstream FIFO depth, i.e. initial credit count (1..15).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 reset_p  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N  per-requester word available.
REQ-007 req_data  in  N*WIDTH  per-requester word, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  out  N  one-hot grant, combinational, at most one bit set.
REQ-009 out_data  out  WIDTH  registered word to the downstream FIFO data_i.
REQ-010 out_we  out  1  registered write strobe to the downstream FIFO data_we.
REQ-011 credit_ret  in  1  one-cycle pulse per word read from the downstream FIFO.
REQ-012 credit_cnt  out  4  current available credits.
REQ-013 credit_err  out  1  sticky error, credit returned while the counter is at CREDITS.

Function
REQ-014 FSM states: WAIT, RUN, HALT.
- WAIT: one cycle after reset release (covers the downstream FIFO's registered reset), then RUN.
- RUN: arbitrates.
- HALT: entered on credit_err; exited only by reset.
REQ-015 Grant only in RUN and only when credit_cnt > 0; no grant otherwise.
REQ-016 Round-robin: search starts at the requester after the last granted one, wrapping N-1 -> 0; requesters with req_valid=0 are skipped.
REQ-017 Transfer = req_valid[i] & req_ready[i]; the requester drops or advances its word in the same cycle.
REQ-018 Transfer in cycle t -> out_we=1 and out_data=req_data[i] in cycle t+1; latency is exactly 1 cycle.
REQ-019 credit_cnt update per cycle:
- transfer only: -1
- credit_ret only: +1
- both: unchanged
REQ-020 A credit_ret arriving when credit_cnt=0 makes a credit available to arbitration in the next cycle, not the same cycle.
REQ-021 credit_ret with credit_cnt=CREDITS and no transfer: counter holds, credit_err=1 next cycle, FSM -> HALT.
REQ-022 In HALT: req_ready=0 and out_we=0; credit_cnt frozen.
REQ-023 Last-grant pointer advances only on a transfer; it holds when credits run out.
REQ-024 Sustained throughput is one word per cycle while credits remain.

Reset
REQ-025 While reset_p=1, outputs take these values asynchronously:
- out_we=0, out_data=0, req_ready=0
- credit_cnt=CREDITS, credit_err=0
- FSM=WAIT, pointer=N-1 (so requester 0 has first priority)
REQ-026 Reset asserted mid-transfer discards the in-flight word; out_we is cleared immediately.

Configuration
REQ-027 Macro CREDIT_RR_ARB_STALL_CNT_EN defined:
- adds output stall_cnt, 16 bits
- stall_cnt increments each RUN cycle in which any req_valid=1 and credit_cnt=0
- stall_cnt saturates at 0xFFFF and resets to 0
REQ-028 Macro undefined: the stall_cnt port and its counter are absent; all other behaviour is identical.

Structure
REQ-029 Package credit_pkg holds:
- FSM state enum (WAIT, RUN, HALT)
- credit counter width constant (4)
- stall counter width constant (16)
REQ-030 Sub-module rr_pick: combinational round-robin picker, inputs req mask and last pointer, outputs one-hot grant; instantiated once.

Verification
REQ-031 Reset release, requester 0 holds req_valid=1:
- no grant in the first cycle (WAIT)
- grant in the second cycle
- out_we one cycle after the grant
REQ-032 All 4 requesters valid, credit_ret held low:
- exactly 8 grants in order 0,1,2,3,0,1,2,3
- credit_cnt then reads 0
- req_ready stays 0 afterwards
REQ-033 credit_cnt=0, one credit_ret pulse:
- credit_cnt=1 next cycle
- exactly one further grant, to requester 0
REQ-034 Simultaneous transfer and credit_ret at credit_cnt=5: credit_cnt stays 5.
REQ-035 Idle system (credit_cnt=8), extra credit_ret pulse:
- credit_err=1 next cycle
- no further grants
- credit_err remains set until reset_p
REQ-036 With CREDIT_RR_ARB_STALL_CNT_EN: requester 2 valid while credit_cnt=0 for 10 RUN cycles -> stall_cnt=10.
